// File: rtl/e203_icb_ram_responder.sv
// ICB responder: word RAM with byte enables, exclusive monitor and a
// 2-entry in-order response queue.
module e203_icb_ram_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
  parameter int          DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icb_cmd_valid,
  output logic        icb_cmd_ready,
  input  logic [31:0] icb_cmd_addr,
  input  logic        icb_cmd_read,
  input  logic [31:0] icb_cmd_wdata,
  input  logic [3:0]  icb_cmd_wmask,
  input  logic [1:0]  icb_cmd_size,
  input  logic        icb_cmd_excl,
  output logic        icb_rsp_valid,
  input  logic        icb_rsp_ready,
  output logic        icb_rsp_err,
  output logic        icb_rsp_excl_ok,
  output logic [31:0] icb_rsp_rdata
);

  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] LIMIT = 33'd4 << DEPTH_LOG2;

  typedef struct packed {
    logic        err;
    logic        ok;
    logic [31:0] rdata;
  } rsp_t;

  logic [31:0]           r_mem [DEPTH];
  logic                  r_res_vld;
  logic [DEPTH_LOG2-1:0] r_res_idx;
  rsp_t                  r_q [2];
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_cnt;

  logic [31:0]           w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_misal;
  logic                  w_err;
  logic                  w_acc;
  logic                  w_pop;
  logic                  w_hit;
  logic                  w_wr;
  rsp_t                  w_rsp;
  rsp_t                  w_head;

  assign w_off = icb_cmd_addr - BASE_ADDR;
  assign w_idx = w_off[DEPTH_LOG2+1:2];

  always_comb begin
    w_misal = 1'b0;
    unique case (icb_cmd_size)
      2'd0:    w_misal = 1'b0;
      2'd1:    w_misal = icb_cmd_addr[0];
      2'd2:    w_misal = |icb_cmd_addr[1:0];
      default: w_misal = 1'b1;
    endcase
  end

  assign w_err = w_misal | ({1'b0, w_off} >= LIMIT);
  assign w_acc = icb_cmd_valid & icb_cmd_ready;
  assign w_pop = icb_rsp_valid & icb_rsp_ready;
  assign w_hit = r_res_vld & (r_res_idx == w_idx);

  // A failed exclusive store is dropped silently (no err, excl_ok=0).
  assign w_wr = w_acc & ~w_err & ~icb_cmd_read
              & (~icb_cmd_excl | w_hit);

  always_comb begin
    w_rsp.err   = w_err;
    w_rsp.ok    = ~w_err & icb_cmd_excl
                & (icb_cmd_read | w_hit);
    w_rsp.rdata = (~w_err & icb_cmd_read)
                ? r_mem[w_idx] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (icb_cmd_wmask[i])
          r_mem[w_idx][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_vld <= 1'b0;
      r_res_idx <= '0;
    end else if (w_acc && !w_err) begin
      if (icb_cmd_read && icb_cmd_excl) begin
        r_res_vld <= 1'b1;
        r_res_idx <= w_idx;
      end else if (!icb_cmd_read && (icb_cmd_excl || w_hit)) begin
        r_res_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q[0] <= '0;
      r_q[1] <= '0;
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_acc) begin
        r_q[r_wp] <= w_rsp;
        r_wp      <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_acc} - {1'b0, w_pop};
    end
  end

  assign w_head          = r_q[r_rp];
  assign icb_cmd_ready   = (r_cnt != 2'd2);
  assign icb_rsp_valid   = (r_cnt != 2'd0);
  assign icb_rsp_err     = icb_rsp_valid & w_head.err;
  assign icb_rsp_excl_ok = icb_rsp_valid & w_head.ok;
  assign icb_rsp_rdata   = icb_rsp_valid ? w_head.rdata : 32'h0;

endmodule

// File: tb/tb_e203_icb_ram_responder.sv
// Directed vector bench for e203_icb_ram_responder.
// Table of commands with expected responses plus backpressure/reset cases.
module tb_e203_icb_ram_responder;

  logic        clk;
  logic        rst_n;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic [1:0]  icb_cmd_size;
  logic        icb_cmd_excl;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err;
  logic        icb_rsp_excl_ok;
  logic [31:0] icb_rsp_rdata;

  e203_icb_ram_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .icb_cmd_valid   (icb_cmd_valid),
    .icb_cmd_ready   (icb_cmd_ready),
    .icb_cmd_addr    (icb_cmd_addr),
    .icb_cmd_read    (icb_cmd_read),
    .icb_cmd_wdata   (icb_cmd_wdata),
    .icb_cmd_wmask   (icb_cmd_wmask),
    .icb_cmd_size    (icb_cmd_size),
    .icb_cmd_excl    (icb_cmd_excl),
    .icb_rsp_valid   (icb_rsp_valid),
    .icb_rsp_ready   (icb_rsp_ready),
    .icb_rsp_err     (icb_rsp_err),
    .icb_rsp_excl_ok (icb_rsp_excl_ok),
    .icb_rsp_rdata   (icb_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [1:0]  size;
    logic        ex;
    logic        e_err;
    logic        e_ok;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tv[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic rd, logic [31:0] a,
                              logic [31:0] d, logic [3:0] m,
                              logic [1:0] s, logic ex,
                              logic ee, logic eo,
                              logic [31:0] er);
    vec_t v;
    v.rd = rd; v.addr = a; v.wdata = d; v.wmask = m;
    v.size = s; v.ex = ex; v.e_err = ee; v.e_ok = eo;
    v.e_rd = er;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic rd, logic [31:0] a,
                       logic [31:0] d, logic [3:0] m,
                       logic [1:0] s, logic ex);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a;
    icb_cmd_wdata = d;
    icb_cmd_wmask = m;
    icb_cmd_size  = s;
    icb_cmd_excl  = ex;
  endtask

  // Called #1 after a posedge with rsp_ready=1.
  task automatic apply(vec_t v, int k);
    drive(v.rd, v.addr, v.wdata, v.wmask, v.size, v.ex);
    chk($sformatf("v%0d cmd_ready", k), 32'(icb_cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    icb_cmd_valid = 1'b0;
    chk($sformatf("v%0d rsp_valid", k), 32'(icb_rsp_valid), 32'd1);
    chk($sformatf("v%0d err", k), 32'(icb_rsp_err), 32'(v.e_err));
    chk($sformatf("v%0d excl_ok", k), 32'(icb_rsp_excl_ok), 32'(v.e_ok));
    chk($sformatf("v%0d rdata", k), icb_rsp_rdata, v.e_rd);
  endtask

  initial begin
    rst_n         = 1'b0;
    icb_cmd_valid = 1'b0;
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = 32'h0;
    icb_cmd_wdata = 32'h0;
    icb_cmd_wmask = 4'h0;
    icb_cmd_size  = 2'd0;
    icb_cmd_excl  = 1'b0;
    icb_rsp_ready = 1'b1;

    tv.push_back(mk(0, 32'h9000_0010, 32'hDEAD_BEEF, 4'hF, 2, 0, 0, 0, 32'h0));
    tv.push_back(mk(1, 32'h9000_0010, 32'h0, 4'h0, 2, 0, 0, 0, 32'hDEAD_BEEF));
    tv.push_back(mk(0, 32'h9000_0011, 32'h0000_AB00, 4'h2, 0, 0, 0, 0, 32'h0));
    tv.push_back(mk(1, 32'h9000_0010, 32'h0, 4'h0, 2, 0, 0, 0, 32'hDEAD_ABEF));
    tv.push_back(mk(1, 32'h9000_0002, 32'h0, 4'h0, 2, 0, 1, 0, 32'h0));
    tv.push_back(mk(1, 32'h9000_1000, 32'h0, 4'h0, 2, 0, 1, 0, 32'h0));
    tv.push_back(mk(1, 32'h9000_0000, 32'h0, 4'h0, 3, 0, 1, 0, 32'h0));
    tv.push_back(mk(0, 32'h9000_0010, 32'hFFFF_FFFF, 4'hF, 3, 0, 1, 0, 32'h0));
    tv.push_back(mk(0, 32'h8FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 2, 0, 1, 0, 32'h0));
    tv.push_back(mk(1, 32'h9000_0010, 32'h0, 4'h0, 2, 0, 0, 0, 32'hDEAD_ABEF));
    tv.push_back(mk(0, 32'h9000_0FFC, 32'h1122_3344, 4'hF, 2, 0, 0, 0, 32'h0));
    tv.push_back(mk(0, 32'h9000_0FFF, 32'h9900_0000, 4'h8, 0, 0, 0, 0, 32'h0));
    tv.push_back(mk(1, 32'h9000_0FFC, 32'h0, 4'h0, 2, 0, 0, 0, 32'h9922_3344));
    tv.push_back(mk(0, 32'h9000_0020, 32'h0, 4'hF, 2, 0, 0, 0, 32'h0));
    tv.push_back(mk(1, 32'h9000_0020, 32'h0, 4'h0, 2, 1, 0, 1, 32'h0));
    tv.push_back(mk(0, 32'h9000_0020, 32'h1234, 4'hF, 2, 1, 0, 1, 32'h0));
    tv.push_back(mk(0, 32'h9000_0020, 32'h5678, 4'hF, 2, 1, 0, 0, 32'h0));
    tv.push_back(mk(1, 32'h9000_0020, 32'h0, 4'h0, 2, 0, 0, 0, 32'h1234));
    tv.push_back(mk(1, 32'h9000_0020, 32'h0, 4'h0, 2, 1, 0, 1, 32'h1234));
    tv.push_back(mk(0, 32'h9000_0020, 32'h9, 4'hF, 2, 0, 0, 0, 32'h0));
    tv.push_back(mk(0, 32'h9000_0020, 32'h7, 4'hF, 2, 1, 0, 0, 32'h0));
    tv.push_back(mk(1, 32'h9000_0020, 32'h0, 4'h0, 2, 0, 0, 0, 32'h9));
    tv.push_back(mk(1, 32'h9000_0020, 32'h0, 4'h0, 2, 1, 0, 1, 32'h9));
    tv.push_back(mk(1, 32'h9000_0024, 32'h0, 4'h0, 3, 1, 1, 0, 32'h0));
    tv.push_back(mk(0, 32'h9000_0020, 32'hA, 4'hF, 2, 1, 0, 1, 32'h0));
    tv.push_back(mk(0, 32'h9000_0022, 32'hBEEF_0000, 4'hC, 1, 0, 0, 0, 32'h0));
    tv.push_back(mk(1, 32'h9000_0021, 32'h0, 4'h0, 1, 0, 1, 0, 32'h0));
    tv.push_back(mk(1, 32'h9000_0020, 32'h0, 4'h0, 2, 0, 0, 0, 32'hBEEF_000A));
    tv.push_back(mk(0, 32'h9000_0040, 32'hA1, 4'hF, 2, 0, 0, 0, 32'h0));
    tv.push_back(mk(0, 32'h9000_0044, 32'hA2, 4'hF, 2, 0, 0, 0, 32'h0));
    tv.push_back(mk(0, 32'h9000_0048, 32'hA3, 4'hF, 2, 0, 0, 0, 32'h0));

    #12;
    chk("rst rsp_valid", 32'(icb_rsp_valid), 32'd0);
    chk("rst rsp_err", 32'(icb_rsp_err), 32'd0);
    chk("rst excl_ok", 32'(icb_rsp_excl_ok), 32'd0);
    chk("rst rdata", icb_rsp_rdata, 32'h0);
    chk("rst cmd_ready", 32'(icb_cmd_ready), 32'd1);
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tv[k]) apply(tv[k], k);
    @(posedge clk);
    #1;
    chk("drain rsp_valid", 32'(icb_rsp_valid), 32'd0);

    // Backpressure: three reads with rsp_ready low.
    icb_rsp_ready = 1'b0;
    drive(1, 32'h9000_0040, 32'h0, 4'h0, 2, 0);
    @(posedge clk);
    #1;
    chk("bp1 cmd_ready", 32'(icb_cmd_ready), 32'd1);
    chk("bp1 rdata", icb_rsp_rdata, 32'hA1);
    drive(1, 32'h9000_0044, 32'h0, 4'h0, 2, 0);
    @(posedge clk);
    #1;
    chk("bp2 cmd_ready", 32'(icb_cmd_ready), 32'd0);
    drive(1, 32'h9000_0048, 32'h0, 4'h0, 2, 0);
    @(posedge clk);
    #1;
    chk("bp3 cmd_ready", 32'(icb_cmd_ready), 32'd0);
    chk("bp3 hold valid", 32'(icb_rsp_valid), 32'd1);
    chk("bp3 hold rdata", icb_rsp_rdata, 32'hA1);
    icb_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp4 cmd_ready", 32'(icb_cmd_ready), 32'd1);
    chk("bp4 rdata", icb_rsp_rdata, 32'hA2);
    @(posedge clk);
    #1;
    icb_cmd_valid = 1'b0;
    chk("bp5 valid", 32'(icb_rsp_valid), 32'd1);
    chk("bp5 rdata", icb_rsp_rdata, 32'hA3);
    @(posedge clk);
    #1;
    chk("bp6 valid", 32'(icb_rsp_valid), 32'd0);

    // Reset with two queued responses.
    icb_rsp_ready = 1'b0;
    drive(1, 32'h9000_0010, 32'h0, 4'h0, 2, 0);
    @(posedge clk);
    #1;
    drive(1, 32'h9000_0040, 32'h0, 4'h0, 2, 0);
    @(posedge clk);
    #1;
    icb_cmd_valid = 1'b0;
    chk("rq full", 32'(icb_cmd_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rq rsp_valid", 32'(icb_rsp_valid), 32'd0);
    chk("rq cmd_ready", 32'(icb_cmd_ready), 32'd1);
    #1 rst_n = 1'b1;
    icb_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(1, 32'h9000_0010, 32'h0, 4'h0, 2, 0, 0, 0, 32'hDEAD_ABEF), 100);
    apply(mk(1, 32'h9000_0020, 32'h0, 4'h0, 2, 0, 0, 0, 32'hBEEF_000A), 101);
    // Reservation was discarded by reset, so this excl store must fail.
    apply(mk(0, 32'h9000_0020, 32'h55, 4'hF, 2, 1, 0, 0, 32'h0), 102);
    apply(mk(1, 32'h9000_0020, 32'h0, 4'h0, 2, 0, 0, 0, 32'hBEEF_000A), 103);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
